instr_fetch_queue: RTL

// - Instruction fetch stage upstream of the CPU control unit. Owns the fetch PC, issues

---
 rtl/instr_fetch_queue.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues 1-cycle-latency imem reads and buffers
// returned instructions in a small prefetch FIFO. Optional macro FETCH_PERF_EN adds stall_cnt.
module instr_fetch_queue #(
    parameter int              DEPTH    = 4,
    parameter int              ADDR_W   = 8,
    parameter int              DATA_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ADDR_W-1:0] fetch_pc;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_addr;

    logic [DATA_W-1:0] buf_data [DEPTH];
    logic [ADDR_W-1:0] buf_pc   [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic [CNT_W-1:0] credit;

    logic credit_ok;
    logic push;
    logic pop;
    logic load_head;
    logic head_bypass;

    // Slots already spoken for: buffered entries plus the read still in flight
    assign credit     = count + CNT_W'(inflight);
    assign credit_ok  = credit < CNT_W'(DEPTH);
    assign inst_valid = (count != '0);
    assign imem_addr  = fetch_pc;

    // Next-state and request strobe; redirect overrides every state
    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        unique case (state)
            IDLE:    if (en) state_nxt = FETCH;
            FETCH:   if (!en) state_nxt = IDLE;
            FLUSH:   state_nxt = en ? FETCH : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (redirect) begin
            state_nxt = FLUSH;
        end
        imem_req = (state == FETCH) && en && !redirect && credit_ok;
    end

    // FIFO control: push/pop qualification and next head location
    always_comb begin
        push        = inflight && (state != FLUSH) && !redirect;
        pop         = inst_valid && inst_ready && !redirect;
        rd_nxt      = rd_ptr + PTR_W'(pop);
        count_nxt   = count;
        if (redirect) begin
            count_nxt = '0;
        end else begin
            count_nxt = count + CNT_W'(push) - CNT_W'(pop);
        end
        load_head   = (count_nxt != '0);
        head_bypass = push && (wr_ptr == rd_nxt);
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Fetch PC and in-flight read tracking
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc      <= RESET_PC;
            inflight      <= 1'b0;
            inflight_addr <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                inflight_addr <= fetch_pc;
            end
            if (redirect) begin
                fetch_pc <= redirect_pc;
            end else if (imem_req) begin
                fetch_pc <= fetch_pc + ADDR_W'(1);
            end
        end
    end

    // FIFO storage; the credit check keeps a push away from a full FIFO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_data[i] <= '0;
                buf_pc[i]   <= '0;
            end
        end else begin
            assert (!(push && count == CNT_W'(DEPTH)));
            if (push) begin
                buf_data[wr_ptr] <= imem_rdata;
                buf_pc[wr_ptr]   <= inflight_addr;
            end
        end
    end

    // FIFO pointers and occupancy; redirect empties the queue
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_nxt;
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                rd_ptr <= rd_nxt;
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
            end
        end
    end

    // Registered head; holds its last value whenever the FIFO goes empty
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inst    <= '0;
            inst_pc <= '0;
        end else if (load_head) begin
            if (head_bypass) begin
                inst    <= imem_rdata;
                inst_pc <= inflight_addr;
            end else begin
                inst    <= buf_data[rd_nxt];
                inst_pc <= buf_pc[rd_nxt];
            end
        end
    end

`ifdef FETCH_PERF_EN
    // Saturating count of fetch cycles blocked only by lack of FIFO credit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (state == FETCH && en && !credit_ok && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
